// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receive and transmit paths: run state,
// default slot geometry and the bit-clock divider legality check.
package i2s_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

    localparam int I2S_BCLK_DIV_DEFAULT = 8;
    localparam int I2S_SLOT_DEFAULT     = 32;
    localparam int I2S_WIDTH_DEFAULT    = 24;

    // The divider must split evenly into high and low phases and leave the
    // data synchronizer at least two clk of settling before the sample point.
    function automatic logic bclk_div_ok(input int div);
        return (div >= 4) && ((div % 2) == 0);
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master bit/word clock generator shared by receiver and transmitter.
// Optional MCLK output (clk/2) is enabled by defining I2S_RX_MCLK_EN.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = I2S_BCLK_DIV_DEFAULT,
    parameter int SLOT     = I2S_SLOT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    output logic [$clog2(2 * SLOT)-1:0]   bit_cnt,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          mclk,
    output logic                          sample_stb,
    output logic                          fall_stb
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SLOT_V   = BW'(SLOT);

    logic [DW-1:0] div_cnt_r, div_next_s;
    logic [BW-1:0] bit_cnt_r, bit_next_s;
    logic          bclk_r, lrck_r;

    // Next divider/bit position; both collapse to zero whenever not running.
    always_comb begin
        div_next_s = DIV_ZERO;
        bit_next_s = BIT_ZERO;
        if (run) begin
            if (div_cnt_r == DIV_LAST) begin
                div_next_s = DIV_ZERO;
                if (bit_cnt_r == BIT_LAST) begin
                    bit_next_s = BIT_ZERO;
                end else begin
                    bit_next_s = bit_cnt_r + BIT_ONE;
                end
            end else begin
                div_next_s = div_cnt_r + DIV_ONE;
                bit_next_s = bit_cnt_r;
            end
        end else begin
            div_next_s = DIV_ZERO;
            bit_next_s = BIT_ZERO;
        end
    end

    // Counters, with bclk/lrck registered from the next count so they track it glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= DIV_ZERO;
            bit_cnt_r <= BIT_ZERO;
            bclk_r    <= 1'b0;
            lrck_r    <= 1'b0;
        end else begin
            div_cnt_r <= div_next_s;
            bit_cnt_r <= bit_next_s;
            bclk_r    <= (div_next_s >= DIV_HALF);
            lrck_r    <= (bit_next_s >= SLOT_V);
        end
    end

`ifdef I2S_RX_MCLK_EN
    logic mclk_r;

    // Master clock at clk/2 while running, parked low otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            mclk_r <= 1'b0;
        end else if (run) begin
            mclk_r <= ~mclk_r;
        end else begin
            mclk_r <= 1'b0;
        end
    end

    assign mclk = mclk_r;
`else
    assign mclk = 1'b0;
`endif

    assign bit_cnt    = bit_cnt_r;
    assign bclk       = bclk_r;
    assign lrck       = lrck_r;
    assign sample_stb = run && (div_cnt_r == DIV_LAST);
    assign fall_stb   = run && (div_cnt_r == DIV_ZERO);

endmodule

// File: rtl/i2s_rx.sv
// Master-mode I2S receiver delivering stereo pairs over valid/ready with a
// sticky overflow flag. Define I2S_RX_MCLK_EN to drive mclk at clk/2.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = I2S_BCLK_DIV_DEFAULT,
    parameter int SLOT     = I2S_SLOT_DEFAULT,
    parameter int WIDTH    = I2S_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sd_in,
    output logic             bclk,
    output logic             lrck,
    output logic             mclk,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int BW = $clog2(2 * SLOT);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);
    localparam logic [BW-1:0] L_FIRST  = BW'(1);
    localparam logic [BW-1:0] L_LAST   = BW'(WIDTH);
    localparam logic [BW-1:0] R_FIRST  = BW'(SLOT + 1);
    localparam logic [BW-1:0] R_LAST   = BW'(SLOT + WIDTH);

    if (!bclk_div_ok(BCLK_DIV) || (WIDTH > SLOT - 1) || (WIDTH < 2)) begin : g_bad_cfg
        $error("i2s_rx: illegal BCLK_DIV/SLOT/WIDTH combination");
    end

    i2s_state_e      state_r, state_next_s;
    logic            run_s;
    logic [1:0]      sync_r;
    logic            sd_s;
    logic [BW-1:0]   bit_cnt_s;
    logic            sample_stb_s, fall_stb_s;
    logic            in_left_s, in_right_s, frame_done_s, load_s, drop_s;
    logic [WIDTH-1:0] left_sh_r, right_sh_r;
    logic [WIDTH-1:0] left_data_r, right_data_r;
    logic            valid_r, overflow_r;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV),
        .SLOT     (SLOT)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .run        (run_s),
        .bit_cnt    (bit_cnt_s),
        .bclk       (bclk),
        .lrck       (lrck),
        .mclk       (mclk),
        .sample_stb (sample_stb_s),
        .fall_stb   (fall_stb_s)
    );

    // Run state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state; the bus only runs in a RUN cycle that is not being left.
    always_comb begin
        state_next_s = IDLE;
        run_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
                run_s = 1'b0;
            end
            RUN: begin
                if (en) begin
                    state_next_s = RUN;
                    run_s        = 1'b1;
                end else begin
                    state_next_s = IDLE;
                    run_s        = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
                run_s        = 1'b0;
            end
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial data line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], sd_in};
        end
    end

    assign sd_s         = sync_r[1];
    assign in_left_s    = (bit_cnt_s >= L_FIRST) && (bit_cnt_s <= L_LAST);
    assign in_right_s   = (bit_cnt_s >= R_FIRST) && (bit_cnt_s <= R_LAST);
    assign frame_done_s = sample_stb_s && (bit_cnt_s == R_LAST);
    assign load_s       = frame_done_s && (!valid_r || ready);
    assign drop_s       = frame_done_s && valid_r && !ready;

    // Serial capture, MSB first with the one-bit I2S delay; a partial frame is discarded.
    always_ff @(posedge clk) begin
        if (rst || !run_s || (fall_stb_s && (bit_cnt_s == BIT_ZERO))) begin
            left_sh_r  <= {WIDTH{1'b0}};
            right_sh_r <= {WIDTH{1'b0}};
        end else if (sample_stb_s) begin
            if (in_left_s) begin
                left_sh_r <= {left_sh_r[WIDTH-2:0], sd_s};
            end
            if (in_right_s) begin
                right_sh_r <= {right_sh_r[WIDTH-2:0], sd_s};
            end
        end
    end

    // Output pair, handshake and sticky overflow; a set on the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_data_r  <= {WIDTH{1'b0}};
            right_data_r <= {WIDTH{1'b0}};
            valid_r      <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (load_s) begin
                left_data_r  <= left_sh_r;
                right_data_r <= {right_sh_r[WIDTH-2:0], sd_s};
                valid_r      <= 1'b1;
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign left_data  = left_data_r;
    assign right_data = right_data_r;
    assign valid      = valid_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: a cycle-count ADC/consumer model predicts
// every output each cycle; scripted frames pin the model with literal values.
module tb_i2s_rx;

    localparam int DIV   = 8;
    localparam int SLOT  = 32;
    localparam int WIDTH = 24;
    localparam int FB    = 2 * SLOT;
    localparam int FRAME = FB * DIV;

    logic clk = 1'b0;
    logic rst, en, sd_in, ready, clr_overflow;
    logic bclk, lrck, mclk, valid, overflow;
    logic [WIDTH-1:0] left_data, right_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          pad;   // 0, 1, or 2 = random pad bits
    } frame_t;

    frame_t script[$];
    frame_t cur;

    bit          m_run = 1'b0;
    int          m_c = 0;
    logic [23:0] e_l = 24'h0, e_r = 24'h0;
    bit          e_valid = 1'b0, e_ovf = 1'b0;
    bit          chk_on = 1'b0;

    i2s_rx #(.BCLK_DIV(DIV), .SLOT(SLOT), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .sd_in(sd_in),
        .bclk(bclk), .lrck(lrck), .mclk(mclk),
        .left_data(left_data), .right_data(right_data),
        .valid(valid), .ready(ready),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances once per clk from the spec's timing arithmetic.
    initial begin : model
        bit done, drop;
        int pos;
        cur = '{24'h0, 24'h0, 0};
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 1'b0; m_c = 0; e_l = 24'h0; e_r = 24'h0;
                e_valid = 1'b0; e_ovf = 1'b0;
            end else begin
                done = 1'b0;
                if (m_run) begin
                    pos  = (m_c / DIV) % FB;
                    done = ((m_c % DIV) == DIV - 1) && (pos == SLOT + WIDTH);
                end
                drop = done && e_valid && !ready;
                if (done && !drop) begin
                    e_l = cur.l; e_r = cur.r; e_valid = 1'b1;
                end else if (e_valid && ready) begin
                    e_valid = 1'b0;
                end
                if (drop) e_ovf = 1'b1;
                else if (clr_overflow) e_ovf = 1'b0;
                if (m_run && en) m_c++;
                else m_c = 0;
                m_run = en;
                if (m_run && ((m_c % FRAME) == 0)) begin
                    if (script.size() > 0) cur = script.pop_front();
                    else begin
                        cur.l = 24'($urandom); cur.r = 24'($urandom); cur.pad = 2;
                    end
                end
            end
        end
    end

    function automatic logic adc_bit();
        int pos, k;
        logic [23:0] w;
        if (!m_run) return 1'($urandom);
        pos = (m_c / DIV) % FB;
        k   = pos % SLOT;
        w   = (pos >= SLOT) ? cur.r : cur.l;
        if (k >= 1 && k <= WIDTH) return w[WIDTH-k];
        if (cur.pad == 2) return 1'($urandom);
        return (cur.pad == 1);
    endfunction

    // ADC: the bit for the current frame position, changed just after each edge.
    initial begin
        sd_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sd_in = adc_bit();
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            logic eb, el, em;
            eb = m_run && ((m_c % DIV) >= DIV / 2);
            el = m_run && (((m_c / DIV) % FB) >= SLOT);
`ifdef I2S_RX_MCLK_EN
            em = m_run && ((m_c % 2) == 1);
`else
            em = 1'b0;
`endif
            check("bclk", bclk, eb);
            check("lrck", lrck, el);
            check("mclk", mclk, em);
            check("valid", valid, e_valid);
            check("overflow", overflow, e_ovf);
            check("left_data", left_data, e_l);
            check("right_data", right_data, e_r);
        end
    end

    task automatic wait_high(input string name, input bit use_ovf, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(use_ovf ? overflow : valid) && n < limit);
        check(name, use_ovf ? overflow : valid, 1'b1);
    endtask

    task automatic measure(input bit use_lrck, output int period);
        logic prev, now;
        int n, t0;
        period = -1; n = 0; t0 = -1;
        prev = use_lrck ? lrck : bclk;
        while (n < 3000 && period < 0) begin
            @(negedge clk);
            n++;
            now = use_lrck ? lrck : bclk;
            if (now && !prev) begin
                if (t0 < 0) t0 = n;
                else period = n - t0;
            end
            prev = now;
        end
    endtask

    initial begin
        int act, per, n;
        rst = 1'b1; en = 1'b0; ready = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_left", left_data, 24'h0);
        check("rst_right", right_data, 24'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_bclk", bclk, 1'b0);
        @(posedge clk); #1; rst = 1'b0;

        act = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bclk || lrck) act++;
        end
        check("idle_bus_activity", act, 0);

        script.push_back('{24'h123456, 24'hABCDEF, 0});
        script.push_back('{24'h800000, 24'h7FFFFF, 1});
        script.push_back('{24'h00000F, 24'hFFFFF0, 2});
        script.push_back('{24'h5A5A5A, 24'hA5A5A5, 2});
        @(posedge clk); #1; en = 1'b1; ready = 1'b1;

        wait_high("f1_valid_seen", 1'b0, 1200);
        check("f1_left", left_data, 24'h123456);
        check("f1_right", right_data, 24'hABCDEF);
        @(negedge clk);
        check("f1_valid_one_clk", valid, 1'b0);

        wait_high("f2_valid_seen", 1'b0, 1200);
        check("f2_left_min", left_data, 24'h800000);
        check("f2_right_max", right_data, 24'h7FFFFF);
        @(posedge clk); #1; ready = 1'b0;

        measure(1'b1, per);
        check("lrck_period", per, 512);
        measure(1'b0, per);
        check("bclk_period", per, 8);

        wait_high("ovf_seen", 1'b1, 2000);
        check("ovf_held_left", left_data, 24'h00000F);
        check("ovf_held_right", right_data, 24'hFFFFF0);
        @(posedge clk); #1; ready = 1'b1;
        @(negedge clk);
        check("a_accept_valid", valid, 1'b1);
        check("a_accept_left", left_data, 24'h00000F);
        @(negedge clk);
        check("a_consumed", valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        @(posedge clk); #1; clr_overflow = 1'b1;
        @(posedge clk); #1; clr_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 1'b0);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_run && ((m_c / DIV) % FB) == 10 && (m_c % DIV) == 0) && n < 2000);
        check("reach_bit10", n < 2000, 1'b1);
        @(posedge clk); #1; en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drop_bclk", bclk, 1'b0);
        check("drop_lrck", lrck, 1'b0);
        act = 0;
        repeat (600) begin
            @(negedge clk);
            if (valid || bclk) act++;
        end
        check("drop_no_activity", act, 0);

        script.push_back('{24'h13579B, 24'h2468AC, 2});
        @(posedge clk); #1; en = 1'b1;
        wait_high("reen_valid_seen", 1'b0, 1200);
        check("reen_left", left_data, 24'h13579B);
        check("reen_right", right_data, 24'h2468AC);

        repeat (20 * FRAME) begin
            @(posedge clk); #1;
            ready        = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1; ready = 1'b1; clr_overflow = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
